// File: rtl/sprite_pkg.sv
// Shared types for the sprite descriptor queue: the descriptor layout and the
// handshake state encoding.
package sprite_pkg;

    typedef struct packed {
        logic [15:0] id;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] width;
        logic [15:0] height;
        logic [31:0] address;
    } sprite_desc_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RELEASE = 2'd2
    } sq_state_e;

    function automatic logic is_zero_size(input sprite_desc_t d);
        return (d.width == 16'd0) || (d.height == 16'd0);
    endfunction

endpackage

// File: rtl/sprite_queue_if.sv
// Push side, status and drawer handshake of the sprite queue, bundled so the
// producer/drawer side and the queue see matching directions.
interface sprite_queue_if #(parameter int DEPTH = 8);

    logic                     wr_en;
    logic [15:0]              wr_id;
    logic [15:0]              wr_x;
    logic [15:0]              wr_y;
    logic [15:0]              wr_width;
    logic [15:0]              wr_height;
    logic [31:0]              wr_address;
    logic                     flush;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic [15:0]              sprite_id;
    logic [15:0]              sprite_x;
    logic [15:0]              sprite_y;
    logic [15:0]              sprite_width;
    logic [15:0]              sprite_height;
    logic [31:0]              sprite_address;
    logic                     draw_sprite;
    logic                     done_draw;
    logic                     busy;
    logic [15:0]              drawn_count;

    modport master (
        output wr_en, wr_id, wr_x, wr_y, wr_width, wr_height, wr_address, flush, done_draw,
        input  full, count, overflow, sprite_id, sprite_x, sprite_y, sprite_width,
               sprite_height, sprite_address, draw_sprite, busy, drawn_count
    );

    modport slave (
        input  wr_en, wr_id, wr_x, wr_y, wr_width, wr_height, wr_address, flush, done_draw,
        output full, count, overflow, sprite_id, sprite_x, sprite_y, sprite_width,
               sprite_height, sprite_address, draw_sprite, busy, drawn_count
    );

endinterface

// File: rtl/sprite_desc_fifo.sv
// Descriptor storage ring with registered count and full; a pop frees a slot on
// the same edge, so a full ring still accepts a push that coincides with a pop.
module sprite_desc_fifo
    import sprite_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          i_push,
    input  sprite_desc_t  i_push_desc,
    input  logic          i_pop,
    input  logic          i_flush,
    output sprite_desc_t  o_head,
    output logic [CW-1:0] o_count,
    output logic          o_full
);

    sprite_desc_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;

    logic          w_push_ok;
    logic          w_pop_ok;
    logic [CW-1:0] w_count_nxt;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_pop_ok    = i_pop && (r_count != '0);
        w_push_ok   = i_push && (!r_full || w_pop_ok);
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop_ok)
            w_count_nxt = r_count + CW'(1);
        else if (w_pop_ok && !w_push_ok)
            w_count_nxt = r_count - CW'(1);
    end

    // NOTE: storage is deliberately not reset; pointers alone define validity.
    always_ff @(posedge Clk) begin
        if (w_push_ok && !i_flush)
            r_mem[r_wr_ptr] <= i_push_desc;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else if (i_flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = r_full;

endmodule

// File: rtl/sprite_queue.sv
// Sprite descriptor queue feeding a drawer through a level handshake:
// IDLE pops and issues, ISSUE waits for done_draw, RELEASE waits for its drop.
module sprite_queue
    import sprite_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input logic           Clk,
    input logic           Reset,
    sprite_queue_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    sq_state_e     r_state;
    sprite_desc_t  r_sprite;
    logic          r_draw_sprite;
    logic          r_busy;
    logic          r_overflow;
    logic [15:0]   r_drawn_count;

    sprite_desc_t  w_wr_desc;
    sprite_desc_t  w_head;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_pop;

    assign w_wr_desc = {bus.wr_id, bus.wr_x, bus.wr_y, bus.wr_width, bus.wr_height, bus.wr_address};

    // A flush wins over a pop on the same edge: nothing queued is issued.
    assign w_pop = (r_state == ST_IDLE) && (w_count != '0) && !bus.flush;

    sprite_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clk         (Clk),
        .Reset       (Reset),
        .i_push      (bus.wr_en),
        .i_push_desc (w_wr_desc),
        .i_pop       (w_pop),
        .i_flush     (bus.flush),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state       <= ST_IDLE;
            r_sprite      <= '0;
            r_draw_sprite <= 1'b0;
            r_busy        <= 1'b0;
            r_overflow    <= 1'b0;
            r_drawn_count <= '0;
        end else begin
            if (bus.wr_en && w_full && !w_pop && !bus.flush)
                r_overflow <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop && !is_zero_size(w_head)) begin
                        r_sprite      <= w_head;
                        r_draw_sprite <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.done_draw) begin
                        r_draw_sprite <= 1'b0;
                        r_state       <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!bus.done_draw) begin
                        r_drawn_count <= r_drawn_count + 16'd1;
                        r_busy        <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_draw_sprite <= 1'b0;
                    r_busy        <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.full           = w_full;
    assign bus.count          = w_count;
    assign bus.overflow       = r_overflow;
    assign bus.sprite_id      = r_sprite.id;
    assign bus.sprite_x       = r_sprite.x;
    assign bus.sprite_y       = r_sprite.y;
    assign bus.sprite_width   = r_sprite.width;
    assign bus.sprite_height  = r_sprite.height;
    assign bus.sprite_address = r_sprite.address;
    assign bus.draw_sprite    = r_draw_sprite;
    assign bus.busy           = r_busy;
    assign bus.drawn_count    = r_drawn_count;

endmodule
